// File: rtl/store_stage_queue.sv
// store_stage_queue
//
// Store front end that sits between LSU issue and the store/AMO buffers.
// Each incoming store or AMO is translated through the MMU. It is then parked
// in a DEPTH-entry staging FIFO, so store-buffer back-pressure no longer
// stalls translation or writeback.
//
// Ports
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   flush_i                  drop all speculative state (FIFO, FSM, writeback)
//   valid_i .. trans_id_i    store/AMO request from LSU issue
//   pop_o                    request consumed (translated or excepted)
//   translation_req_o        MMU request, vaddr_o = vaddr_i
//   dtlb_hit_i, paddr_i,     MMU response (same cycle)
//   ex_valid_i
//   valid_o, trans_id_o,     writeback, one cycle after pop_o
//   ex_valid_o
//   st_valid_o/st_ready_i    head entry handshake toward the store buffer
//   amo_valid_o/amo_ready_i  head entry handshake toward the AMO buffer
//   head_*_o                 head entry fields (zero while empty)
//   count_o                  FIFO occupancy
module store_stage_queue #(
  parameter int XLEN          = 64,
  parameter int VLEN          = 64,
  parameter int PLEN          = 56,
  parameter int TRANS_ID_BITS = 3,
  parameter int DEPTH         = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       valid_i,
  input  logic [VLEN-1:0]            vaddr_i,
  input  logic [XLEN-1:0]            data_i,
  input  logic [XLEN/8-1:0]          be_i,
  input  logic [1:0]                 size_i,
  input  logic [3:0]                 amo_op_i,
  input  logic [TRANS_ID_BITS-1:0]   trans_id_i,
  output logic                       pop_o,
  output logic                       translation_req_o,
  output logic [VLEN-1:0]            vaddr_o,
  input  logic                       dtlb_hit_i,
  input  logic [PLEN-1:0]            paddr_i,
  input  logic                       ex_valid_i,
  output logic                       valid_o,
  output logic [TRANS_ID_BITS-1:0]   trans_id_o,
  output logic                       ex_valid_o,
  output logic                       st_valid_o,
  input  logic                       st_ready_i,
  output logic                       amo_valid_o,
  input  logic                       amo_ready_i,
  output logic [PLEN-1:0]            head_paddr_o,
  output logic [XLEN-1:0]            head_data_o,
  output logic [XLEN/8-1:0]          head_be_o,
  output logic [1:0]                 head_size_o,
  output logic [3:0]                 head_amo_op_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int CW       = $clog2(DEPTH + 1);
  localparam int PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BEW      = XLEN / 8;
  // Byte-offset bits inside one XLEN word.
  localparam int OFF_BITS = (XLEN == 64) ? 3 : 2;

  typedef struct packed {
    logic [PLEN-1:0] paddr;
    logic [XLEN-1:0] data;
    logic [BEW-1:0]  be;
    logic [1:0]      size;
    logic [3:0]      amo_op;
  } entry_t;

  typedef enum logic {
    IDLE,
    WAIT_TRANSLATION
  } state_t;

  state_t           state_reg, state_next;
  entry_t           mem [0:DEPTH-1];
  logic [PW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]    count_reg;

  logic                     wb_valid_reg;
  logic [TRANS_ID_BITS-1:0] wb_trans_id_reg;
  logic                     wb_ex_reg;

  logic   empty, full, head_is_amo, amo_held, can_accept;
  logic   push, drain;
  entry_t head;
  entry_t push_entry;
  logic [OFF_BITS+2:0] shamt;

  function automatic logic [PW-1:0] inc_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // ---------------------------------------------------------------------------
  // Occupancy and acceptance
  // ---------------------------------------------------------------------------
  assign empty = (count_reg == '0);
  assign full  = (count_reg == CW'(DEPTH));

  // Head is read combinationally from the register array, so its fields are
  // valid in the same cycle the entry becomes resident.
  assign head        = mem[rd_ptr_reg];
  assign head_is_amo = (head.amo_op != 4'd0);

  // An AMO only ever enters an empty FIFO and blocks everything behind it,
  // so a resident AMO is always the head entry.
  assign amo_held = !empty && head_is_amo;

  // Depends only on registered state and the request: a same-cycle drain
  // never opens a slot, which keeps ready -> pop_o free of combinational paths.
  assign can_accept = !full && !amo_held && ((amo_op_i == 4'd0) || empty);

  // ---------------------------------------------------------------------------
  // Translation FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next        = state_reg;
    translation_req_o = 1'b0;
    pop_o             = 1'b0;
    push              = 1'b0;

    case (state_reg)
      IDLE: begin
        if (valid_i && can_accept) begin
          translation_req_o = 1'b1;
          if (ex_valid_i) begin
            // Excepting request retires through writeback only.
            pop_o = 1'b1;
          end else if (dtlb_hit_i) begin
            pop_o = 1'b1;
            push  = 1'b1;
          end else begin
            state_next = WAIT_TRANSLATION;
          end
        end
      end
      WAIT_TRANSLATION: begin
        // Acceptance was decided on entry; the request is held upstream and
        // the FIFO cannot gain entries meanwhile, so the slot is still free.
        translation_req_o = 1'b1;
        if (ex_valid_i) begin
          pop_o      = 1'b1;
          state_next = IDLE;
        end else if (dtlb_hit_i) begin
          pop_o      = 1'b1;
          push       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    // Flush discards whatever this cycle would have consumed or stored.
    if (flush_i) begin
      pop_o      = 1'b0;
      push       = 1'b0;
      state_next = IDLE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  assign vaddr_o = vaddr_i;

  // ---------------------------------------------------------------------------
  // Push entry: plain stores are aligned to their byte lane, AMOs keep the
  // operand in the low bits.
  // ---------------------------------------------------------------------------
  assign shamt = {vaddr_i[OFF_BITS-1:0], 3'b000};

  always_comb begin
    push_entry.paddr  = paddr_i;
    push_entry.data   = (amo_op_i == 4'd0) ? (data_i << shamt) : data_i;
    push_entry.be     = be_i;
    push_entry.size   = size_i;
    push_entry.amo_op = amo_op_i;
  end

  // Storage needs no reset: count_reg qualifies every read.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr_reg] <= push_entry;
    end
  end

  // ---------------------------------------------------------------------------
  // Drain toward store / AMO buffers
  // ---------------------------------------------------------------------------
  assign st_valid_o  = !empty && !head_is_amo;
  assign amo_valid_o = !empty && head_is_amo;
  assign drain       = (st_valid_o && st_ready_i) || (amo_valid_o && amo_ready_i);

  assign head_paddr_o  = empty ? '0 : head.paddr;
  assign head_data_o   = empty ? '0 : head.data;
  assign head_be_o     = empty ? '0 : head.be;
  assign head_size_o   = empty ? '0 : head.size;
  assign head_amo_op_o = empty ? '0 : head.amo_op;
  assign count_o       = count_reg;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush_i) begin
      // A drain accepted downstream in this cycle still completes there; the
      // entry is dropped here along with the rest.
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= inc_ptr(wr_ptr_reg);
      end
      if (drain) begin
        rd_ptr_reg <= inc_ptr(rd_ptr_reg);
      end
      // push is never asserted when full, so this cannot overflow.
      count_reg <= count_reg + CW'(push) - CW'(drain);
    end
  end

  // ---------------------------------------------------------------------------
  // Writeback: one cycle after every pop
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wb_valid_reg    <= 1'b0;
      wb_trans_id_reg <= '0;
      wb_ex_reg       <= 1'b0;
    end else begin
      wb_valid_reg <= pop_o && !flush_i;
      if (pop_o) begin
        wb_trans_id_reg <= trans_id_i;
        wb_ex_reg       <= ex_valid_i;
      end
    end
  end

  assign valid_o    = wb_valid_reg;
  assign trans_id_o = wb_trans_id_reg;
  assign ex_valid_o = wb_ex_reg;

endmodule

// File: doc/store_stage_queue.md
Name: store_stage_queue

Overview:
- Parametrised successor to the single-entry store front end in the LSU.
- Sits between LSU issue and the store buffer / AMO buffer.
- Translates each store, then parks the translated store in a DEPTH-entry staging FIFO. Store-buffer back-pressure therefore no longer stalls translation or writeback.
- Supports XLEN 32/64 and routes AMOs to a separate port with depth-1 ordering.

Parameters:
XLEN, 64, data width (32 or 64)
VLEN, 64, virtual address width
PLEN, 56, physical address width
TRANS_ID_BITS, 3, scoreboard transaction id width
DEPTH, 2, staging FIFO entries (>=1; power of two not required)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
flush_i  in  1  drop all speculative state
valid_i  in  1  store/AMO request valid
vaddr_i  in  VLEN  virtual address
data_i  in  XLEN  unaligned store data
be_i  in  XLEN/8  byte enables (already aligned)
size_i  in  2  transfer size
amo_op_i  in  4  AMO op code, 0 = plain store
trans_id_i  in  TRANS_ID_BITS  transaction id
pop_o  out  1  request consumed
translation_req_o  out  1  MMU request
vaddr_o  out  VLEN  address to MMU (= vaddr_i)
dtlb_hit_i  in  1  translation hit, same cycle
paddr_i  in  PLEN  translated address
ex_valid_i  in  1  translation/access exception
valid_o  out  1  writeback valid
trans_id_o  out  TRANS_ID_BITS  writeback id
ex_valid_o  out  1  writeback carries exception
st_valid_o  out  1  head is plain store
st_ready_i  in  1  store buffer accepts
amo_valid_o  out  1  head is AMO
amo_ready_i  in  1  AMO buffer accepts
head_paddr_o  out  PLEN  head entry fields
head_data_o  out  XLEN
head_be_o  out  XLEN/8
head_size_o  out  2
head_amo_op_o  out  4
count_o  out  $clog2(DEPTH+1)  occupancy

Behaviour:
- Clock and reset: one clock, clk_i. Reset is asynchronous and active-low on rst_ni.
- Reset values: all outputs 0, FIFO empty, FSM IDLE.
- FSM has two states, IDLE and WAIT_TRANSLATION.
- can_accept = !full && !amo_held && (amo_op_i==0 || count==0).
  - amo_held: an AMO entry is resident in the FIFO.
  - An AMO is accepted only into an empty FIFO. Nothing is accepted behind it.
- IDLE:
  - Condition: valid_i && can_accept.
  - Action: translation_req_o=1.
  - On dtlb_hit_i && !ex_valid_i: pop_o=1 and push the entry.
  - On !dtlb_hit_i: go to WAIT_TRANSLATION.
- WAIT_TRANSLATION:
  - translation_req_o held at 1. Request inputs are held stable by upstream.
  - On hit: pop_o=1, push the entry, go to IDLE.
- Exception: ex_valid_i while translation_req_o=1 gives pop_o=1, no push, state IDLE.
- Writeback:
  - Any pop_o produces valid_o=1 exactly one cycle later.
  - trans_id_o = registered trans_id_i.
  - ex_valid_o = registered ex_valid_i.
- Push data alignment:
  - Plain store: data left-shifted by 8*vaddr_i[2:0] for XLEN=64, or 8*vaddr_i[1:0] for XLEN=32, truncated to XLEN.
  - AMO: data unshifted.
- Drain:
  - If non-empty, the head drives st_valid_o (amo_op==0) or amo_valid_o (otherwise).
  - Pop on valid&&ready. Head fields are stable while valid.
- Full FIFO: can_accept=0, so no translation_req_o and no pop_o.
  - A same-cycle drain does not enable a push; there is no combinational path ready -> pop_o.
- Simultaneous push and drain (not full): count is unchanged, pointers both advance, wrap at DEPTH-1 -> 0.
- flush_i, highest priority:
  - FIFO emptied, FSM to IDLE.
  - Registered writeback valid cleared, so valid_o=0 next cycle.
  - A push or pop in the same cycle is discarded.
  - A drain handshake in the same cycle still completes downstream, but the entry is dropped regardless.
- Reset mid-operation: immediate return to reset values.

Test Plan:
- Back-to-back plain stores:
  - Stimulus: ids 1,2,3 with hits, st_ready_i=1.
  - Required: pop_o on 3 consecutive cycles; valid_o/trans_id_o 1,2,3 each one cycle later; st_valid_o carries each entry.
- Back-pressure:
  - Stimulus: DEPTH=2, st_ready_i=0, 3 stores.
  - Required: first two accepted, count_o=2; third sees translation_req_o=0; releasing st_ready_i drains in order and the third is accepted.
- TLB miss:
  - Stimulus: dtlb_hit_i=0 for 4 cycles, then 1.
  - Required: translation_req_o high 5 cycles; pop_o only on the hit cycle; valid_o the next cycle.
- Exception:
  - Stimulus: ex_valid_i=1 on the hit cycle, id 5.
  - Required: pop_o=1, count_o unchanged; next cycle valid_o=1, ex_valid_o=1, trans_id_o=5.
- AMO ordering:
  - Stimulus: store then AMO_ADD then store.
  - Required: AMO waits until count_o=0 and is unshifted; the following store waits until amo_valid_o&&amo_ready_i.
- Alignment and flush:
  - Stimulus: XLEN=64, vaddr=0x...3, data=0xAB.
  - Required: head_data_o=0xAB000000.
  - Stimulus: flush_i with 2 entries.
  - Required: count_o=0 and valid_o=0 next cycle.
